// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with overlap/non-overlap modes.
// Ports: clk, rst (sync, active-high), x/in_valid (serial bit + qualifier),
//   overlap (mode), cnt_clr (counter clear), q (1-cycle match pulse, 1-cycle
//   latency from the accepting edge), match_cnt (saturating match count),
//   fill (valid history bits held, 0..SEQ_LEN).
// Optional feature macro: SEQ_DET_MATCH_CNT_EN enables the match counter and
//   cnt_clr; without it match_cnt is tied to 0 and cnt_clr is ignored.
module seq_detector_param #(
  parameter int                 SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1010,
  parameter int                 CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           x,
  input  logic                           in_valid,
  input  logic                           overlap,
  input  logic                           cnt_clr,
  output logic                           q,
  output logic [CNT_W-1:0]               match_cnt,
  output logic [$clog2(SEQ_LEN+1)-1:0]   fill
);

  localparam int            FW   = $clog2(SEQ_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(SEQ_LEN);
  localparam logic [FW-1:0] LAST = FW'(SEQ_LEN - 1);

  // ARMED mirrors fill == SEQ_LEN; FILLING covers every fill below that.
  typedef enum logic {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEQ_LEN-1:0] r_win;
  logic [SEQ_LEN-1:0] w_win_nxt;
  logic [SEQ_LEN-1:0] w_win_shift;
  logic [FW-1:0]      r_fill;
  logic [FW-1:0]      w_fill_nxt;
  logic               r_q;
  logic               w_complete;
  logic               w_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILLING;
      r_win   <= '0;
      r_fill  <= '0;
      r_q     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_win   <= w_win_nxt;
      r_fill  <= w_fill_nxt;
      r_q     <= w_match;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_win_nxt   = r_win;
    w_fill_nxt  = r_fill;
    w_match     = 1'b0;
    w_complete  = 1'b0;
    w_win_shift = {r_win[SEQ_LEN-2:0], x};

    if (in_valid) begin
      w_win_nxt = w_win_shift;
      // A match is only possible once the window will be fully valid after
      // this shift; at that point every window bit is fresh, so a full-width
      // compare is exactly the compare over valid bits.
      w_complete = (r_state == ARMED) || (r_fill == LAST);
      if (w_complete) begin
        w_match = (w_win_shift == PATTERN);
        if (w_match && !overlap) begin
          // Non-overlapping: restart collection from scratch on the same edge.
          w_fill_nxt  = '0;
          w_state_nxt = FILLING;
        end else begin
          w_fill_nxt  = FULL;
          w_state_nxt = ARMED;
        end
      end else begin
        w_fill_nxt  = r_fill + 1'b1;
        w_state_nxt = FILLING;
      end
    end
  end

  assign q    = r_q;
  assign fill = r_fill;

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Clear wins over a coincident match; the pulse on q is unaffected.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_match && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign match_cnt = r_cnt;
`else
  logic w_unused_cnt_clr;

  assign w_unused_cnt_clr = cnt_clr;
  assign match_cnt        = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed, table-driven bench for seq_detector_param: default config
// (1010), a CNT_W=2 instance for saturation/clear, and SEQ_LEN=3/111.
module tb_seq_detector_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic x = 1'b0;
  logic in_valid = 1'b0;
  logic overlap = 1'b0;
  logic cnt_clr = 1'b0;

  logic       q_a;
  logic [7:0] cnt_a;
  logic [2:0] fill_a;
  logic       q_b;
  logic [1:0] cnt_b;
  logic [2:0] fill_b;
  logic       q_c;
  logic [7:0] cnt_c;
  logic [1:0] fill_c;

  int n_chk = 0;
  int n_err = 0;

  seq_detector_param dut_a (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .overlap(overlap),
    .cnt_clr(cnt_clr), .q(q_a), .match_cnt(cnt_a), .fill(fill_a)
  );

  seq_detector_param #(.SEQ_LEN(4), .PATTERN(4'b1010), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .overlap(overlap),
    .cnt_clr(cnt_clr), .q(q_b), .match_cnt(cnt_b), .fill(fill_b)
  );

  seq_detector_param #(.SEQ_LEN(3), .PATTERN(3'b111), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .overlap(overlap),
    .cnt_clr(cnt_clr), .q(q_c), .match_cnt(cnt_c), .fill(fill_c)
  );

  typedef struct {
    logic r;
    logic vl;
    logic xx;
    logic o;
    logic c;
    logic eq;
    int   ef;
    int   ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic r, logic vl, logic xx, logic o, logic c,
                             logic eq, int ef, int ec);
    vec_t t;
    t.r = r; t.vl = vl; t.xx = xx; t.o = o; t.c = c;
    t.eq = eq; t.ef = ef; t.ec = ec;
    return t;
  endfunction

  // Counter expectations collapse to 0 when the counter is compiled out.
  function automatic int ecnt(int n);
`ifdef SEQ_DET_MATCH_CNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after
  // the rising edge that consumed them.
  task automatic drive(logic r, logic vl, logic xx, logic o, logic c);
    @(negedge clk);
    rst      = r;
    in_valid = vl;
    x        = xx;
    overlap  = o;
    cnt_clr  = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_sat[5];
    logic [3:0] exp_q_c;
    int exp_f_c[4];

    // fields: rst, in_valid, x, overlap, cnt_clr | q, fill, match_cnt
    // reset with every other input active: reset must dominate
    tbl.push_back(v(1,1,1,1,1, 0,0,0));
    // overlapping 1,0,1,0,1,0
    tbl.push_back(v(0,1,1,1,0, 0,1,0));
    tbl.push_back(v(0,1,0,1,0, 0,2,0));
    tbl.push_back(v(0,1,1,1,0, 0,3,0));
    tbl.push_back(v(0,1,0,1,0, 1,4,1));
    tbl.push_back(v(0,1,1,1,0, 0,4,1));
    tbl.push_back(v(0,1,0,1,0, 1,4,2));
    tbl.push_back(v(1,0,0,0,0, 0,0,0));
    // non-overlapping 1,0,1,0,1,0,1,0
    tbl.push_back(v(0,1,1,0,0, 0,1,0));
    tbl.push_back(v(0,1,0,0,0, 0,2,0));
    tbl.push_back(v(0,1,1,0,0, 0,3,0));
    tbl.push_back(v(0,1,0,0,0, 1,0,1));
    tbl.push_back(v(0,1,1,0,0, 0,1,1));
    tbl.push_back(v(0,1,0,0,0, 0,2,1));
    tbl.push_back(v(0,1,1,0,0, 0,3,1));
    tbl.push_back(v(0,1,0,0,0, 1,0,2));
    tbl.push_back(v(1,0,0,0,0, 0,0,0));
    // valid gaps (x=1 during gaps must be ignored)
    tbl.push_back(v(0,1,1,1,0, 0,1,0));
    tbl.push_back(v(0,1,0,1,0, 0,2,0));
    tbl.push_back(v(0,0,1,1,0, 0,2,0));
    tbl.push_back(v(0,0,1,1,0, 0,2,0));
    tbl.push_back(v(0,0,1,1,0, 0,2,0));
    tbl.push_back(v(0,1,1,1,0, 0,3,0));
    tbl.push_back(v(0,1,0,1,0, 1,4,1));
    tbl.push_back(v(0,0,0,1,0, 0,4,1));
    // reset mid-stream after 1,0,1 (reset also beats in_valid)
    tbl.push_back(v(1,0,0,1,0, 0,0,0));
    tbl.push_back(v(0,1,1,1,0, 0,1,0));
    tbl.push_back(v(0,1,0,1,0, 0,2,0));
    tbl.push_back(v(0,1,1,1,0, 0,3,0));
    tbl.push_back(v(1,1,0,1,0, 0,0,0));
    tbl.push_back(v(0,1,0,1,0, 0,1,0));
    tbl.push_back(v(0,1,1,1,0, 0,2,0));
    tbl.push_back(v(0,1,0,1,0, 0,3,0));
    tbl.push_back(v(0,1,1,1,0, 0,4,0));
    tbl.push_back(v(0,1,0,1,0, 1,4,1));
    // mode change while armed leaves fill alone; next match is non-overlap
    tbl.push_back(v(0,0,0,0,0, 0,4,1));
    tbl.push_back(v(0,1,1,0,0, 0,4,1));
    tbl.push_back(v(0,1,0,0,0, 1,0,2));
    // clear without a match
    tbl.push_back(v(0,1,1,0,1, 0,1,0));

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].vl, tbl[i].xx, tbl[i].o, tbl[i].c);
      chk($sformatf("row%0d q", i), int'(q_a), int'(tbl[i].eq));
      chk($sformatf("row%0d fill", i), int'(fill_a), tbl[i].ef);
      chk($sformatf("row%0d cnt", i), int'(cnt_a), ecnt(tbl[i].ec));
    end

    // Saturation on the 2-bit counter: 5 overlapping matches of 1010.
    exp_sat = '{1, 2, 3, 3, 3};
    drive(1, 0, 0, 1, 0);
    chk("sat reset cnt", int'(cnt_b), 0);
    for (int k = 1; k <= 12; k++) begin
      drive(0, 1, (k % 2) == 1, 1, 0);
      if (k >= 4 && (k % 2) == 0) begin
        chk($sformatf("sat q bit%0d", k), int'(q_b), 1);
        chk($sformatf("sat cnt bit%0d", k), int'(cnt_b), ecnt(exp_sat[(k - 4) / 2]));
      end else begin
        chk($sformatf("sat q bit%0d", k), int'(q_b), 0);
      end
    end
    // Clear coincident with a match: pulse still fires, count goes to 0.
    drive(0, 1, 1, 1, 0);
    chk("clr pre q", int'(q_b), 0);
    drive(0, 1, 0, 1, 1);
    chk("clr match q", int'(q_b), 1);
    chk("clr match cnt", int'(cnt_b), 0);
    drive(0, 1, 1, 1, 0);
    drive(0, 1, 0, 1, 0);
    chk("post clr q", int'(q_b), 1);
    chk("post clr cnt", int'(cnt_b), ecnt(1));

    // SEQ_LEN=3, PATTERN=111, overlap: pulses after bits 3 and 4.
    exp_q_c = 4'b1100;
    exp_f_c = '{1, 2, 3, 3};
    drive(1, 0, 0, 1, 0);
    chk("c reset fill", int'(fill_c), 0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 1, 1, 0);
      chk($sformatf("c q bit%0d", k + 1), int'(q_c), int'(exp_q_c[k]));
      chk($sformatf("c fill bit%0d", k + 1), int'(fill_c), exp_f_c[k]);
    end
    drive(0, 0, 1, 1, 0);
    chk("c idle q", int'(q_c), 0);
    chk("c cnt", int'(cnt_c), ecnt(2));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter SEQ_LEN, default 4: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter PATTERN, SEQ_LEN bits wide, default 4'b1010: target sequence, MSB received first.
REQ-003 SHALL have parameter CNT_W, default 8: match-counter width, minimum 2.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port x, input, 1 bit: serial data bit.
REQ-007 SHALL have port in_valid, input, 1 bit: x sampled only when high.
REQ-008 SHALL have port overlap, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping.
REQ-009 SHALL have port cnt_clr, input, 1 bit: synchronous clear of match_cnt.
REQ-010 SHALL have port q, output, 1 bit: registered one-cycle match pulse.
REQ-011 SHALL have port match_cnt, output, CNT_W bits: saturating count of matches.
REQ-012 SHALL have port fill, output, $clog2(SEQ_LEN+1) bits: number of valid history bits currently held, 0..SEQ_LEN.

Function
REQ-013 SHALL keep a SEQ_LEN-bit history window; on in_valid=1, shift x in at the LSB.
REQ-014 SHALL increment fill on each accepted bit, saturating at SEQ_LEN.
REQ-015 SHALL compare the window only across bits that will be valid after the shift.
REQ-016 SHALL detect a match when an accepted bit makes fill reach SEQ_LEN and the updated window equals PATTERN.
REQ-017 SHALL pulse q high for exactly the one cycle after the clock edge that accepted the completing bit; latency is 1 cycle from sample.
REQ-018 SHALL, in overlap=1 mode after a match, keep the window and fill=SEQ_LEN, so later bits may complete further matches.
REQ-019 SHALL, in overlap=0 mode after a match, set fill to 0 on the same edge, so the next match needs SEQ_LEN new bits.
REQ-020 SHALL hold the window, fill and q=0 on any cycle with in_valid=0.
REQ-021 SHALL sample overlap every cycle; a mode change takes effect from the next accepted bit and does not modify fill.
REQ-022 SHALL count a match when match_cnt is below all-ones.
REQ-023 SHALL hold match_cnt at all-ones; it SHALL NOT wrap.
REQ-024 SHALL give cnt_clr priority over a simultaneous match: match_cnt becomes 0 and q still pulses.
REQ-025 SHALL treat fill as the FSM state: FILLING while fill < SEQ_LEN, ARMED at fill = SEQ_LEN; non-overlap match returns to FILLING with fill 0.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, set window to 0, fill to 0, q to 0 and match_cnt to 0.
REQ-027 SHALL give rst priority over in_valid and cnt_clr.
REQ-028 SHALL discard any partial sequence on a reset mid-stream; detection restarts from fill=0.

Configuration
REQ-029 SHALL, with macro SEQ_DET_MATCH_CNT_EN defined, implement the saturating counter and cnt_clr behaviour per REQ-022..024.
REQ-030 SHALL, without SEQ_DET_MATCH_CNT_EN, keep the match_cnt and cnt_clr ports, tie match_cnt to 0, ignore cnt_clr, and leave q and fill behaviour unchanged.

Verification
REQ-031 SHALL verify overlap mode: defaults, overlap=1, in_valid=1, x=1,0,1,0,1,0 -> q pulses after the 4th and 6th bits, and match_cnt=2.
REQ-032 SHALL verify non-overlap mode: same stream with overlap=0 -> q pulses after the 4th bit only, and fill=2 after the 6th bit; adding x=1,0 -> second pulse after the 8th bit.
REQ-033 SHALL verify valid gaps: x=1,0,1,0 with in_valid=0 for 3 cycles between bits 2 and 3 -> single q pulse one cycle after bit 4, and no pulse during gaps.
REQ-034 SHALL verify reset mid-stream: x=1,0,1, then rst=1 for 1 cycle, then x=0 -> no pulse and fill=1; then x=1,0,1,0 -> pulse.
REQ-035 SHALL verify counter saturation with SEQ_DET_MATCH_CNT_EN defined: CNT_W=2, 5 overlapping matches -> match_cnt stays 3; cnt_clr asserted on a match cycle -> match_cnt=0 and q=1.
REQ-036 SHALL verify a second configuration: SEQ_LEN=3, PATTERN=3'b111, overlap=1, x=1,1,1,1 -> pulses after bits 3 and 4.
